// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - opcodes, control encodings, states and control vector for the multi-cycle sequencer
package mc_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BLT   = 6'b000110;
  localparam logic [5:0] OP_BGEZ  = 6'b000001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_RTYPE = 3'b000;
  localparam logic [2:0] ALU_ADD   = 3'b010;
  localparam logic [2:0] ALU_SUB   = 3'b110;
  localparam logic [2:0] ALU_SLT   = 3'b111;

  localparam logic [1:0] BR_EQ  = 2'b00;
  localparam logic [1:0] BR_LT  = 2'b01;
  localparam logic [1:0] BR_GEZ = 2'b10;
  localparam logic [1:0] BR_NE  = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, EXEC_R, R_WB, EXEC_I, I_WB,
    MEM_ADDR, MEM_RD, LW_WB, MEM_WR, BRANCH, JUMP
  } state_t;

  typedef struct packed {
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic [1:0] branch_type;
    logic       instr_done;
  } ctrl_t;

  function automatic logic [1:0] branch_type_of(input logic [5:0] op);
    case (op)
      OP_BNE:  return BR_NE;
      OP_BLT:  return BR_LT;
      OP_BGEZ: return BR_GEZ;
      default: return BR_EQ;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// rtl/mc_ctrl_outdec.sv - combinational state/opcode/ready to datapath control vector decode
module mc_ctrl_outdec
  import mc_ctrl_pkg::*;
(
  input  state_t     state_i,
  input  logic [5:0] op_i,
  input  logic       mem_ready_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.alu_op    = ALU_ADD;
        // IR and PC+4 are only committed once the fetch actually completes
        if (mem_ready_i) begin
          ctrl_o.ir_write  = 1'b1;
          ctrl_o.pc_write  = 1'b1;
          ctrl_o.pc_source = PCS_ALU;
        end
      end
      DECODE: begin
        ctrl_o.alu_src_b = SRCB_IMM_SH2;
        ctrl_o.alu_op    = ALU_ADD;
      end
      EXEC_R: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_REG;
        ctrl_o.alu_op    = ALU_RTYPE;
      end
      R_WB: begin
        ctrl_o.reg_dst    = 1'b1;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      EXEC_I: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = (op_i == OP_SLTI) ? ALU_SLT : ALU_ADD;
      end
      I_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      MEM_ADDR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALU_ADD;
      end
      MEM_RD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.iord     = 1'b1;
      end
      LW_WB: begin
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      MEM_WR: begin
        ctrl_o.mem_write  = 1'b1;
        ctrl_o.iord       = 1'b1;
        ctrl_o.instr_done = mem_ready_i;
      end
      BRANCH: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_src_b     = SRCB_REG;
        ctrl_o.alu_op        = ALU_SUB;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_source     = PCS_ALUOUT;
        ctrl_o.branch_type   = branch_type_of(op_i);
        ctrl_o.instr_done    = 1'b1;
      end
      JUMP: begin
        ctrl_o.pc_write   = 1'b1;
        ctrl_o.pc_source  = PCS_JUMP;
        ctrl_o.instr_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// rtl/multicycle_ctrl_fsm.sv - multi-cycle MIPS-subset control sequencer with memory wait timeout and retire counter
module multicycle_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [5:0]       instr_op_i,
  input  logic             mem_ready_i,
  output logic             IorD_o,
  output logic             MemRead_o,
  output logic             MemWrite_o,
  output logic             IRWrite_o,
  output logic             PCWrite_o,
  output logic             PCWriteCond_o,
  output logic [1:0]       PCSource_o,
  output logic             ALUSrcA_o,
  output logic [1:0]       ALUSrcB_o,
  output logic [2:0]       ALU_op_o,
  output logic             RegDst_o,
  output logic             MemToReg_o,
  output logic             RegWrite_o,
  output logic [1:0]       BranchType_o,
  output logic             instr_done_o,
  output logic [CNT_W-1:0] instr_cnt_o,
  output logic             illegal_o,
  output logic             timeout_o
);

  localparam int WAIT_W = $clog2(WAIT_MAX + 1);

  state_t             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               illegal_q, illegal_d;
  logic               timeout_q, timeout_d;
  logic               mem_state;
  logic               timeout_hit;
  ctrl_t              ctrl;

  mc_ctrl_outdec u_outdec (
    .state_i     (state_q),
    .op_i        (instr_op_i),
    .mem_ready_i (mem_ready_i),
    .ctrl_o      (ctrl)
  );

  assign mem_state   = (state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR);
  // Ready arriving on the limit cycle still wins over the timeout
  assign timeout_hit = mem_state && !mem_ready_i && (wait_q == WAIT_W'(WAIT_MAX));

  always_comb begin
    state_d   = state_q;
    wait_d    = '0;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    cnt_d     = cnt_q + CNT_W'(ctrl.instr_done);
    case (state_q)
      IDLE:     state_d = FETCH;
      FETCH:    if (mem_ready_i) state_d = DECODE;
      DECODE: begin
        case (instr_op_i)
          OP_RTYPE:                       state_d = EXEC_R;
          OP_ADDI, OP_SLTI:               state_d = EXEC_I;
          OP_LW, OP_SW:                   state_d = MEM_ADDR;
          OP_BEQ, OP_BNE, OP_BLT, OP_BGEZ: state_d = BRANCH;
          OP_J:                           state_d = JUMP;
          default: begin
            state_d   = FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      EXEC_R:   state_d = R_WB;
      EXEC_I:   state_d = I_WB;
      MEM_ADDR: state_d = (instr_op_i == OP_LW) ? MEM_RD : MEM_WR;
      MEM_RD:   if (mem_ready_i) state_d = LW_WB;
      MEM_WR:   if (mem_ready_i) state_d = FETCH;
      default:  state_d = FETCH;
    endcase
    if (timeout_hit) begin
      state_d   = FETCH;
      timeout_d = 1'b1;
    end else if (mem_state && !mem_ready_i) begin
      wait_d = wait_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      wait_q    <= '0;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  assign IorD_o        = ctrl.iord;
  assign MemRead_o     = ctrl.mem_read;
  assign MemWrite_o    = ctrl.mem_write;
  assign IRWrite_o     = ctrl.ir_write;
  assign PCWrite_o     = ctrl.pc_write;
  assign PCWriteCond_o = ctrl.pc_write_cond;
  assign PCSource_o    = ctrl.pc_source;
  assign ALUSrcA_o     = ctrl.alu_src_a;
  assign ALUSrcB_o     = ctrl.alu_src_b;
  assign ALU_op_o      = ctrl.alu_op;
  assign RegDst_o      = ctrl.reg_dst;
  assign MemToReg_o    = ctrl.mem_to_reg;
  assign RegWrite_o    = ctrl.reg_write;
  assign BranchType_o  = ctrl.branch_type;
  assign instr_done_o  = ctrl.instr_done;
  assign instr_cnt_o   = cnt_q;
  assign illegal_o     = illegal_q;
  assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb/tb_multicycle_ctrl_fsm.sv - directed self-checking bench for multicycle_ctrl_fsm
module tb_multicycle_ctrl_fsm;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [5:0]  instr_op_i;
  logic        mem_ready_i;
  logic        IorD_o, MemRead_o, MemWrite_o, IRWrite_o, PCWrite_o, PCWriteCond_o;
  logic [1:0]  PCSource_o, ALUSrcB_o, BranchType_o;
  logic        ALUSrcA_o, RegDst_o, MemToReg_o, RegWrite_o, instr_done_o;
  logic [2:0]  ALU_op_o;
  logic [31:0] instr_cnt_o;
  logic        illegal_o, timeout_o;
  logic [19:0] outs;

  int checks = 0;
  int failures = 0;
  int done_seen = 0, regw_seen = 0, irw_seen = 0, pcw_seen = 0;

  multicycle_ctrl_fsm #(.WAIT_MAX(15), .CNT_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .instr_op_i(instr_op_i), .mem_ready_i(mem_ready_i),
    .IorD_o(IorD_o), .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o), .IRWrite_o(IRWrite_o),
    .PCWrite_o(PCWrite_o), .PCWriteCond_o(PCWriteCond_o), .PCSource_o(PCSource_o),
    .ALUSrcA_o(ALUSrcA_o), .ALUSrcB_o(ALUSrcB_o), .ALU_op_o(ALU_op_o), .RegDst_o(RegDst_o),
    .MemToReg_o(MemToReg_o), .RegWrite_o(RegWrite_o), .BranchType_o(BranchType_o),
    .instr_done_o(instr_done_o), .instr_cnt_o(instr_cnt_o), .illegal_o(illegal_o),
    .timeout_o(timeout_o)
  );

  assign outs = {IorD_o, MemRead_o, MemWrite_o, IRWrite_o, PCWrite_o, PCWriteCond_o, PCSource_o,
                 ALUSrcA_o, ALUSrcB_o, ALU_op_o, RegDst_o, MemToReg_o, RegWrite_o,
                 BranchType_o, instr_done_o};

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    if (instr_done_o) done_seen++;
    if (RegWrite_o)   regw_seen++;
    if (IRWrite_o)    irw_seen++;
    if (PCWrite_o)    pcw_seen++;
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b0; mem_ready_i = 1'b1; instr_op_i = 6'b000000;
    repeat (3) cyc();
    settle();
    checks++; if (outs !== 20'h0) begin failures++; $display("FAIL reset_outs got=%h want=00000", outs); end
    checks++; if (instr_cnt_o !== 32'd0) begin failures++; $display("FAIL reset_cnt got=%0d want=0", instr_cnt_o); end
    checks++; if ({illegal_o, timeout_o} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b want=00", {illegal_o, timeout_o}); end
  endtask

  task automatic test_rtype();
    rst_i = 1'b1;
    settle();
    checks++; if (outs !== 20'h0) begin failures++; $display("FAIL idle_outs got=%h want=00000", outs); end
    cyc(); settle();
    checks++; if ({MemRead_o, IorD_o, ALUSrcA_o, ALUSrcB_o, ALU_op_o} !== 8'b1_0_0_01_010) begin failures++; $display("FAIL fetch_ctrl got=%b want=10001010", {MemRead_o, IorD_o, ALUSrcA_o, ALUSrcB_o, ALU_op_o}); end
    checks++; if ({IRWrite_o, PCWrite_o, PCSource_o} !== 4'b1100) begin failures++; $display("FAIL fetch_ready got=%b want=1100", {IRWrite_o, PCWrite_o, PCSource_o}); end
    cyc(); settle();
    checks++; if ({MemRead_o, ALUSrcA_o, ALUSrcB_o, ALU_op_o} !== 7'b0_0_11_010) begin failures++; $display("FAIL decode_ctrl got=%b want=0011010", {MemRead_o, ALUSrcA_o, ALUSrcB_o, ALU_op_o}); end
    cyc(); settle();
    checks++; if ({ALUSrcA_o, ALUSrcB_o, ALU_op_o, RegWrite_o} !== 7'b1_00_000_0) begin failures++; $display("FAIL exec_r got=%b want=1000000", {ALUSrcA_o, ALUSrcB_o, ALU_op_o, RegWrite_o}); end
    cyc(); settle();
    checks++; if ({RegDst_o, RegWrite_o, MemToReg_o, instr_done_o} !== 4'b1101) begin failures++; $display("FAIL r_wb got=%b want=1101", {RegDst_o, RegWrite_o, MemToReg_o, instr_done_o}); end
    checks++; if (instr_cnt_o !== 32'd0) begin failures++; $display("FAIL r_wb_cnt got=%0d want=0", instr_cnt_o); end
    cyc(); settle();
    checks++; if (instr_cnt_o !== 32'd1) begin failures++; $display("FAIL rtype_cnt got=%0d want=1", instr_cnt_o); end
    checks++; if ({MemRead_o, instr_done_o} !== 2'b10) begin failures++; $display("FAIL rtype_back_fetch got=%b want=10", {MemRead_o, instr_done_o}); end
  endtask

  task automatic test_lw();
    int d0;
    d0 = done_seen;
    instr_op_i = 6'b100011; mem_ready_i = 1'b1;
    settle();
    checks++; if (IRWrite_o !== 1'b1) begin failures++; $display("FAIL lw_fetch_irw got=%b want=1", IRWrite_o); end
    cyc(); cyc(); settle();
    checks++; if ({ALUSrcA_o, ALUSrcB_o, ALU_op_o} !== 6'b1_10_010) begin failures++; $display("FAIL lw_mem_addr got=%b want=110010", {ALUSrcA_o, ALUSrcB_o, ALU_op_o}); end
    cyc();
    for (int i = 0; i < 4; i++) begin
      mem_ready_i = (i == 3);
      settle();
      checks++; if ({MemRead_o, IorD_o, instr_done_o} !== 3'b110) begin failures++; $display("FAIL lw_mem_rd[%0d] got=%b want=110", i, {MemRead_o, IorD_o, instr_done_o}); end
      if (i < 3) cyc();
    end
    cyc();
    mem_ready_i = 1'b0;
    settle();
    checks++; if ({RegDst_o, MemToReg_o, RegWrite_o, instr_done_o, MemRead_o} !== 5'b01110) begin failures++; $display("FAIL lw_wb got=%b want=01110", {RegDst_o, MemToReg_o, RegWrite_o, instr_done_o, MemRead_o}); end
    cyc();
    mem_ready_i = 1'b1;
    settle();
    checks++; if (done_seen - d0 !== 1) begin failures++; $display("FAIL lw_done_pulses got=%0d want=1", done_seen - d0); end
    checks++; if (instr_cnt_o !== 32'd2) begin failures++; $display("FAIL lw_cnt got=%0d want=2", instr_cnt_o); end
  endtask

  task automatic test_itype();
    logic [5:0] ops [2];
    logic [2:0] alu [2];
    ops = '{6'b001000, 6'b001010};
    alu = '{3'b010, 3'b111};
    for (int i = 0; i < 2; i++) begin
      instr_op_i = ops[i];
      cyc(); cyc(); settle();
      checks++; if ({ALUSrcA_o, ALUSrcB_o, ALU_op_o} !== {1'b1, 2'b10, alu[i]}) begin failures++; $display("FAIL exec_i[%0d] got=%b want=%b", i, {ALUSrcA_o, ALUSrcB_o, ALU_op_o}, {1'b1, 2'b10, alu[i]}); end
      cyc(); settle();
      checks++; if ({RegDst_o, MemToReg_o, RegWrite_o, instr_done_o} !== 4'b0011) begin failures++; $display("FAIL i_wb[%0d] got=%b want=0011", i, {RegDst_o, MemToReg_o, RegWrite_o, instr_done_o}); end
      cyc();
    end
    settle();
    checks++; if (instr_cnt_o !== 32'd4) begin failures++; $display("FAIL itype_cnt got=%0d want=4", instr_cnt_o); end
  endtask

  task automatic test_branches();
    logic [5:0] ops [4];
    logic [1:0] bt [4];
    ops = '{6'b000100, 6'b000101, 6'b000110, 6'b000001};
    bt  = '{2'b00, 2'b11, 2'b01, 2'b10};
    for (int i = 0; i < 4; i++) begin
      instr_op_i = ops[i];
      cyc(); cyc(); settle();
      checks++; if ({PCWriteCond_o, PCSource_o, ALU_op_o, ALUSrcA_o, ALUSrcB_o, instr_done_o} !== 10'b1_01_110_1_00_1) begin failures++; $display("FAIL branch_ctrl[%0d] got=%b want=1011101001", i, {PCWriteCond_o, PCSource_o, ALU_op_o, ALUSrcA_o, ALUSrcB_o, instr_done_o}); end
      checks++; if (BranchType_o !== bt[i]) begin failures++; $display("FAIL branch_type[%0d] got=%b want=%b", i, BranchType_o, bt[i]); end
      cyc();
    end
    settle();
    checks++; if (instr_cnt_o !== 32'd8) begin failures++; $display("FAIL branch_cnt got=%0d want=8", instr_cnt_o); end
  endtask

  task automatic test_sw_jump();
    instr_op_i = 6'b101011;
    cyc(); cyc(); cyc(); settle();
    checks++; if ({MemWrite_o, IorD_o, MemRead_o, instr_done_o} !== 4'b1101) begin failures++; $display("FAIL sw_mem_wr got=%b want=1101", {MemWrite_o, IorD_o, MemRead_o, instr_done_o}); end
    cyc();
    instr_op_i = 6'b000010;
    cyc(); cyc(); settle();
    checks++; if ({PCWrite_o, PCSource_o, instr_done_o} !== 4'b1101) begin failures++; $display("FAIL jump_ctrl got=%b want=1101", {PCWrite_o, PCSource_o, instr_done_o}); end
    cyc(); settle();
    checks++; if (instr_cnt_o !== 32'd10) begin failures++; $display("FAIL sw_j_cnt got=%0d want=10", instr_cnt_o); end
  endtask

  task automatic test_illegal();
    int r0;
    r0 = regw_seen;
    instr_op_i = 6'b111111;
    cyc(); settle();
    checks++; if ({illegal_o, ALUSrcB_o} !== 3'b011) begin failures++; $display("FAIL illegal_decode got=%b want=011", {illegal_o, ALUSrcB_o}); end
    cyc(); settle();
    checks++; if ({illegal_o, MemRead_o} !== 2'b11) begin failures++; $display("FAIL illegal_flag got=%b want=11", {illegal_o, MemRead_o}); end
    checks++; if (instr_cnt_o !== 32'd10) begin failures++; $display("FAIL illegal_cnt got=%0d want=10", instr_cnt_o); end
    checks++; if (regw_seen !== r0) begin failures++; $display("FAIL illegal_regwrite got=%0d want=%0d", regw_seen, r0); end
  endtask

  task automatic test_timeout();
    int i0, p0;
    i0 = irw_seen; p0 = pcw_seen;
    instr_op_i = 6'b000010; mem_ready_i = 1'b0;
    settle();
    for (int k = 1; k <= 16; k++) begin
      cyc(); settle();
      if (k == 15) begin
        checks++; if (timeout_o !== 1'b0) begin failures++; $display("FAIL timeout_early got=%b want=0", timeout_o); end
      end
      if (k == 16) begin
        checks++; if ({timeout_o, illegal_o, MemRead_o} !== 3'b111) begin failures++; $display("FAIL timeout_flag got=%b want=111", {timeout_o, illegal_o, MemRead_o}); end
      end
    end
    checks++; if ({irw_seen, pcw_seen} !== {i0, p0}) begin failures++; $display("FAIL timeout_writes got=%0d/%0d want=%0d/%0d", irw_seen, pcw_seen, i0, p0); end
    for (int k = 1; k <= 15; k++) cyc();
    mem_ready_i = 1'b1;
    settle();
    checks++; if ({IRWrite_o, PCWrite_o} !== 2'b11) begin failures++; $display("FAIL ready_at_limit got=%b want=11", {IRWrite_o, PCWrite_o}); end
    cyc(); settle();
    checks++; if ({MemRead_o, ALUSrcB_o} !== 3'b011) begin failures++; $display("FAIL limit_decode got=%b want=011", {MemRead_o, ALUSrcB_o}); end
    cyc(); cyc(); settle();
    checks++; if ({instr_cnt_o, timeout_o} !== {32'd11, 1'b1}) begin failures++; $display("FAIL limit_cnt got=%0d/%b want=11/1", instr_cnt_o, timeout_o); end
  endtask

  task automatic test_reset_mid_memwr();
    instr_op_i = 6'b101011;
    cyc(); cyc(); cyc();
    mem_ready_i = 1'b0;
    settle();
    checks++; if (MemWrite_o !== 1'b1) begin failures++; $display("FAIL memwr_before_rst got=%b want=1", MemWrite_o); end
    rst_i = 1'b0;
    settle();
    checks++; if (outs !== 20'h0) begin failures++; $display("FAIL async_rst_outs got=%h want=00000", outs); end
    checks++; if ({instr_cnt_o, illegal_o, timeout_o} !== 34'd0) begin failures++; $display("FAIL async_rst_state got=%0d/%b/%b want=0/0/0", instr_cnt_o, illegal_o, timeout_o); end
    cyc();
    rst_i = 1'b1; mem_ready_i = 1'b1;
    cyc(); settle();
    checks++; if ({MemRead_o, MemWrite_o} !== 2'b10) begin failures++; $display("FAIL post_rst_fetch got=%b want=10", {MemRead_o, MemWrite_o}); end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw();
    test_itype();
    test_branches();
    test_sw_jump();
    test_illegal();
    test_timeout();
    test_reset_mid_memwr();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
